// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream, instruction-memory write and status bundle for
//               the instruction-memory loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if;
    logic        start;
    logic [15:0] load_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    modport master (
        output start, load_words, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, checksum
    );

    modport slave (
        input  start, load_words, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, checksum
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Assembles a little-endian byte stream into 32-bit words and
//               writes them to consecutive instruction-memory word addresses.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic         clock,
    input  logic         reset,
    imem_loader_if.slave bus
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] csum_q, csum_d;
    logic [15:0] rem_q, rem_d;
    logic        err_q, err_d;
    logic        oversize;

    assign oversize = {16'd0, bus.load_words} > c_DEPTH;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;
        rem_d   = rem_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.load_words == 16'd0) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                        csum_d  = '0;
                    end else if (oversize) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                        err_d   = 1'b0;
                        csum_d  = '0;
                        idx_d   = '0;
                        addr_d  = '0;
                        rem_d   = bus.load_words;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.byte_valid) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Write address and data are latched here so they stay
                        // stable on the bus until the next word is written.
                        wdata_d = {bus.byte_data, buf_q};
                        maddr_d = addr_q;
                        state_d = S_WRITE;
                    end else begin
                        buf_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 32'd4;
                csum_d  = csum_q + wdata_q;
                rem_d   = rem_q - 16'd1;
                idx_d   = '0;
                state_d = (rem_q == 16'd1) ? S_DONE : S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            maddr_q <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready = (state_q == S_COLLECT);
    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.checksum   = csum_q;
    assign bus.error      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Randomised self-checking bench for imem_loader against a
//               word-list/checksum reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    imem_loader_if bus ();

    imem_loader #(.DEPTH_WORDS(1024)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];

    logic [7:0]  img[$];
    logic [31:0] exp_words[$];
    logic [31:0] exp_sum;

    always @(posedge clock) cyc <= cyc + 1;

    // Write/done monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_wdata);
            obs_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic make_image(input int n);
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    task automatic build_model();
        logic [31:0] w;
        exp_words.delete();
        exp_sum = 0;
        for (int i = 0; i < img.size() / 4; i++) begin
            w = 32'(img[4*i]) + (32'(img[4*i+1]) << 8) + (32'(img[4*i+2]) << 16)
              + (32'(img[4*i+3]) << 24);
            exp_words.push_back(w);
            exp_sum = exp_sum + w;
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        bus.start      = 1'b1;
        bus.load_words = n;
        @(posedge clock); #1;
        bus.start      = 1'b0;
        bus.load_words = 16'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok);
        int gaps;
        ok = 1'b0;
        gaps = 0;
        while (($urandom_range(99) < gap_pct) && (gaps < 8)) begin
            @(posedge clock); #1;
            gaps++;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            if (bus.byte_ready === 1'b1) ok = 1'b1;
            @(posedge clock); #1;
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    // Full session: start, stream img, wait for done; mid_idx >= 0 injects a start while busy
    task automatic run_load(input int n, input int gap_pct, input int mid_idx, output bit ok);
        bit b, seen;
        ok = 1'b1;
        do_start(16'(n));
        for (int i = 0; i < img.size(); i++) begin
            if (i == mid_idx) do_start(16'd5);
            send_byte(img[i], gap_pct, b);
            if (!b) ok = 1'b0;
        end
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) ok = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        bit b;
        @(negedge clock);
        n_tests++;
        if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy,
             bus.done, bus.error, bus.checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b sum=%h, want all 0",
                     bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy,
                     bus.done, bus.error, bus.checksum);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        make_image(2);
        do_start(16'd2);
        for (int i = 0; i < 4; i++) send_byte(img[i], 0, b);
        n_tests++;
        if (bus.mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_we: got %b want 1", bus.mem_we);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy,
             bus.done, bus.error, bus.checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got ready=%b we=%b addr=%h data=%h busy=%b sum=%h, want all 0",
                     bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.checksum);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if ({bus.busy, bus.byte_ready, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got busy/ready/done=%b want 000",
                     {bus.busy, bus.byte_ready, bus.done});
        end
        @(posedge clock); #1;
    endtask

    task automatic test_two_word();
        bit ok;
        int wb, db;
        logic [7:0] fixed [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        img.delete();
        foreach (fixed[i]) img.push_back(fixed[i]);
        wb = obs_addr.size();
        db = done_cnt;
        run_load(2, 0, -1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL two_word_timeout: got 0 want 1"); end
        n_tests++;
        if (obs_addr.size() - wb != 2) begin
            n_fail++;
            $display("FAIL two_word_count: got %0d want 2", obs_addr.size() - wb);
        end else begin
            n_tests++;
            if (obs_addr[wb] !== 32'h0 || obs_data[wb] !== 32'h00000013) begin
                n_fail++;
                $display("FAIL two_word_w0: got %h@%h want 00000013@00000000", obs_data[wb], obs_addr[wb]);
            end
            n_tests++;
            if (obs_addr[wb+1] !== 32'h4 || obs_data[wb+1] !== 32'h00100093) begin
                n_fail++;
                $display("FAIL two_word_w1: got %h@%h want 00100093@00000004", obs_data[wb+1], obs_addr[wb+1]);
            end
            n_tests++;
            if (last_done_cyc != obs_cyc[wb+1] + 1) begin
                n_fail++;
                $display("FAIL two_word_done_lat: got cycle %0d want %0d", last_done_cyc, obs_cyc[wb+1] + 1);
            end
        end
        n_tests++;
        if (bus.checksum !== 32'h001000A6) begin
            n_fail++;
            $display("FAIL two_word_sum: got %h want 001000a6", bus.checksum);
        end
        n_tests++;
        if (done_cnt - db != 1) begin
            n_fail++;
            $display("FAIL two_word_done_cnt: got %0d want 1", done_cnt - db);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL two_word_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_random_loads(input int iters, input int gap_pct);
        bit ok;
        int wb, n, bad;
        for (int k = 0; k < iters; k++) begin
            n = $urandom_range(6, 1);
            if (k == 0) begin
                img.delete();
                img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
                n = 2;
            end else begin
                make_image(n);
            end
            build_model();
            wb = obs_addr.size();
            run_load(n, gap_pct, -1, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rand_timeout: iter %0d", k); end
            n_tests++;
            if (obs_addr.size() - wb != n) begin
                n_fail++;
                $display("FAIL rand_count: iter %0d got %0d want %0d", k, obs_addr.size() - wb, n);
            end else begin
                bad = 0;
                for (int i = 0; i < n; i++)
                    if (obs_addr[wb+i] !== 32'(4*i) || obs_data[wb+i] !== exp_words[i]) bad++;
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL rand_writes: iter %0d got %0d bad words want 0", k, bad);
                end
            end
            n_tests++;
            if (bus.checksum !== exp_sum) begin
                n_fail++;
                $display("FAIL rand_sum: iter %0d got %h want %h", k, bus.checksum, exp_sum);
            end
        end
    endtask

    task automatic test_zero_len();
        int wb;
        wb = obs_addr.size();
        do_start(16'd0);
        @(negedge clock);
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: got done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (obs_addr.size() != wb) begin
            n_fail++;
            $display("FAIL zero_len_writes: got %0d want 0", obs_addr.size() - wb);
        end
    endtask

    task automatic test_oversize();
        int wb;
        wb = obs_addr.size();
        do_start(16'd1025);
        @(negedge clock);
        n_tests++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_err: got error=%b busy=%b want 1 0", bus.error, bus.busy);
        end
        repeat (4) @(negedge clock);
        n_tests++;
        if (obs_addr.size() != wb || bus.busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_idle: got writes=%0d busy=%b ready=%b want 0 0 0",
                     obs_addr.size() - wb, bus.busy, bus.byte_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_full_depth();
        bit ok;
        int wb, bad;
        make_image(1024);
        build_model();
        wb = obs_addr.size();
        run_load(1024, 0, -1, ok);
        n_tests++;
        if (!ok || obs_addr.size() - wb != 1024) begin
            n_fail++;
            $display("FAIL full_count: got ok=%0d writes=%0d want 1 1024", ok, obs_addr.size() - wb);
        end else begin
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (obs_addr[wb+i] !== 32'(4*i) || obs_data[wb+i] !== exp_words[i]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL full_writes: got %0d bad words want 0", bad);
            end
            n_tests++;
            if (obs_addr[wb+1023] !== 32'd4092) begin
                n_fail++;
                $display("FAIL full_last_addr: got %h want %h", obs_addr[wb+1023], 32'd4092);
            end
        end
        n_tests++;
        if (bus.checksum !== exp_sum || bus.error !== 1'b0) begin
            n_fail++;
            $display("FAIL full_sum: got sum=%h err=%b want %h 0", bus.checksum, bus.error, exp_sum);
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        int wb;
        make_image(2);
        build_model();
        wb = obs_addr.size();
        run_load(2, 0, 3, ok);
        repeat (8) @(posedge clock);
        #1;
        n_tests++;
        if (!ok || obs_addr.size() - wb != 2) begin
            n_fail++;
            $display("FAIL ignored_start_count: got ok=%0d writes=%0d want 1 2", ok, obs_addr.size() - wb);
        end
        n_tests++;
        if (bus.checksum !== exp_sum || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_sum: got sum=%h busy=%b want %h 0", bus.checksum, bus.busy, exp_sum);
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok, b;
        int wb;
        make_image(2);
        do_start(16'd2);
        for (int i = 0; i < 6; i++) send_byte(img[i], 20, b);
        #2 reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        wb = obs_addr.size();
        make_image(1);
        build_model();
        run_load(1, 20, -1, ok);
        n_tests++;
        if (!ok || obs_addr.size() - wb != 1) begin
            n_fail++;
            $display("FAIL mid_reset_count: got ok=%0d writes=%0d want 1 1", ok, obs_addr.size() - wb);
        end else begin
            n_tests++;
            if (obs_addr[wb] !== 32'h0 || obs_data[wb] !== exp_words[0]) begin
                n_fail++;
                $display("FAIL mid_reset_write: got %h@%h want %h@00000000",
                         obs_data[wb], obs_addr[wb], exp_words[0]);
            end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.load_words = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        test_reset();
        test_two_word();
        test_random_loads(1, 40);
        test_random_loads(5, 30);
        test_zero_len();
        test_oversize();
        test_full_depth();
        test_ignored_start();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Instruction-memory writer: the write-side counterpart to the PC-driven fetch path, which reads instruction memory one word per step. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes them to sequential word-aligned addresses starting at 0, so a program image can be loaded into instruction memory before the core or fetch stepper is released. Reports completion, a running checksum and a length error.

## Interface

- `DEPTH_WORDS`, default 1024: instruction-memory capacity in words (4096 bytes; last valid address 4092).
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1  begin a load session; sampled only when `busy`=0.
- `load_words`  in  16  number of words to load; sampled with an accepted `start`.
- `byte_valid`  in  1  `byte_data` holds a byte.
- `byte_data`  in  8  incoming image byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  32  byte address of write, word-aligned (bits [1:0]=0).
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.
- `error`  out  1  sticky: last `start` requested `load_words` > `DEPTH_WORDS`.
- `checksum`  out  32  sum mod 2^32 of all words written this session.

## Operation

- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE: `byte_ready`=0, `busy`=0. On `start`=1:
  - `load_words`=0: go to DONE, no writes.
  - `load_words` > `DEPTH_WORDS`: set `error`, stay IDLE, no writes.
  - Otherwise: clear `error`, `checksum`, byte index and address; latch word count; go to COLLECT.
- COLLECT: `byte_ready`=1, `busy`=1. A byte is accepted on a rising edge with `byte_valid`&&`byte_ready`. Byte k (0..3) of the current word goes to bits [8k+7:8k]. After byte 3 is accepted, go to WRITE.
- WRITE (exactly one cycle): `mem_we`=1, `byte_ready`=0, `busy`=1, `mem_addr`=current address, `mem_wdata`=assembled word.
  - On exit: address += 4; checksum += word; remaining count −= 1.
  - Remaining count now 0: go to DONE. Otherwise: go to COLLECT with byte index 0.
- DONE (one cycle): `done`=1, `busy`=0, `byte_ready`=0. Next state is IDLE.
  - `start` is also accepted in DONE, with the same rules as IDLE; `done` still pulses that cycle.
- `start` while `busy`=1 is ignored, with no effect on count, address or checksum.
- Address never exceeds 4·(`DEPTH_WORDS`−1), because oversize requests are rejected; no wrap-around occurs.
- `byte_valid` is ignored outside COLLECT, and such bytes are not consumed.
- `mem_addr`, `mem_wdata` and `checksum` hold their last values between writes and after `done`.
- Reset mid-session:
  - Partial word is discarded; FSM goes to IDLE.
  - All outputs are forced to reset values asynchronously, and `mem_we` drops immediately.
  - Memory writes already performed are not undone.

## Timing

- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `checksum`=0.
- `start` accepted at edge N:
  - `busy`=1 and `byte_ready`=1 from cycle N+1.
  - Zero-length case: `done`=1 in cycle N+1.
  - Oversize case: `error`=1 from cycle N+1.
- 4th byte of a word accepted at edge M: `mem_we`=1 during cycle M+1; `checksum` updated from cycle M+2.
- Final write in cycle W: `done`=1 and `busy`=0 in cycle W+1; IDLE from W+2.
- Peak throughput: 5 cycles per word (4 byte handshakes plus 1 write cycle). Gaps in `byte_valid` stall COLLECT indefinitely, with no timeout.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset: assert `reset`=0 mid-run → all outputs read reset values within the same cycle; after release, state is IDLE.
- Two-word load: `load_words`=2, bytes 13 00 00 00 93 00 10 00 sent back-to-back → writes (addr 0x0, data 0x00000013), then (addr 0x4, data 0x00100093). Final `checksum`=0x001000A6; single `done` pulse 1 cycle after the second `mem_we`.
- Backpressure/gaps: same image with `byte_valid` randomly low → identical writes, addresses and checksum; no `mem_we` while `byte_valid` is low in COLLECT.
- Boundaries:
  - `load_words`=0 → `done` next cycle, no `mem_we`.
  - `load_words`=1025 → `error`=1, no writes, `busy` stays 0.
  - `load_words`=1024 → last write at addr 4092.
- Ignored `start`: pulse `start` with `load_words`=5 midway through a 2-word load → exactly 2 writes.
- Reset mid-word: reset after 2 bytes of word 1, then start a fresh 1-word load → a single write at addr 0 with the new data only.
